// File: rtl/comparador_pkg.sv
// Shared constants for the bit-serial comparator: cell state codes and FSM encodings.
package comparador_pkg;

  localparam logic [1:0] ST_EQ = 2'b01;
  localparam logic [1:0] ST_GT = 2'b10;
  localparam logic [1:0] ST_LT = 2'b11;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

endpackage

// File: rtl/comparador_serial_ctrl_celda.sv
// celdaTipica: one left-to-right comparator cell. {p,q} is the verdict so far,
// {P,Q} the verdict after this bit pair. GT/LT absorb; the illegal 00 passes through.
module celdaTipica
  import comparador_pkg::*;
(
  input  logic Ai,
  input  logic Bi,
  input  logic p,
  input  logic q,
  output logic P,
  output logic Q
);

  always_comb begin
    {P, Q} = {p, q};
    if ({p, q} == ST_EQ) begin
      if (Ai && !Bi) begin
        {P, Q} = ST_GT;
      end else if (!Ai && Bi) begin
        {P, Q} = ST_LT;
      end
    end
  end

endmodule

// File: rtl/comparador_serial_ctrl.sv
// Bit-serial N-bit magnitude comparator: one celdaTipica clocked MSB first.
// Optional macro COMPARADOR_EARLY_EXIT_EN ends the run once the verdict is decided.
module comparador_serial_ctrl
  import comparador_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         busy,
  output logic         done,
  output logic         mayor,
  output logic         menor,
  output logic         igual,
  output logic [1:0]   estado
);

  // state   | meaning
  // S_IDLE  | waiting for start; verdict of last run held
  // S_SHIFT | one bit pair per clock through the cell, MSB first
  // S_DONE  | single-cycle done pulse; start here begins the next run
  localparam int CW = $clog2(N) + 1;

  logic [1:0]    state_q, state_d;
  logic [1:0]    pq_q, pq_d;
  logic [N-1:0]  sha_q, sha_d;
  logic [N-1:0]  shb_q, shb_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mayor_q, mayor_d;
  logic          menor_q, menor_d;
  logic          igual_q, igual_d;
  logic          cell_p, cell_q;
  logic [1:0]    pq_next;
  logic          last_bit;

  celdaTipica u_celda (
    .Ai (sha_q[N-1]),
    .Bi (shb_q[N-1]),
    .p  (pq_q[1]),
    .q  (pq_q[0]),
    .P  (cell_p),
    .Q  (cell_q)
  );

  assign pq_next = {cell_p, cell_q};

`ifdef COMPARADOR_EARLY_EXIT_EN
  assign last_bit = (cnt_q == CW'(1)) || (pq_next != ST_EQ);
`else
  assign last_bit = (cnt_q == CW'(1));
`endif

  always_comb begin
    state_d = state_q;
    pq_d    = pq_q;
    sha_d   = sha_q;
    shb_d   = shb_q;
    cnt_d   = cnt_q;
    mayor_d = mayor_q;
    menor_d = menor_q;
    igual_d = igual_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          state_d = S_SHIFT;
          sha_d   = A;
          shb_d   = B;
          pq_d    = ST_EQ;
          cnt_d   = CW'(N);
          mayor_d = 1'b0;
          menor_d = 1'b0;
          igual_d = 1'b0;
        end
      end
      S_SHIFT: begin
        pq_d  = pq_next;
        sha_d = sha_q << 1;
        shb_d = shb_q << 1;
        cnt_d = cnt_q - CW'(1);
        if (last_bit) begin
          state_d = S_DONE;
          mayor_d = (pq_next == ST_GT);
          menor_d = (pq_next == ST_LT);
          igual_d = (pq_next == ST_EQ);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pq_q    <= ST_EQ;
      sha_q   <= '0;
      shb_q   <= '0;
      cnt_q   <= '0;
      mayor_q <= 1'b0;
      menor_q <= 1'b0;
      igual_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pq_q    <= pq_d;
      sha_q   <= sha_d;
      shb_q   <= shb_d;
      cnt_q   <= cnt_d;
      mayor_q <= mayor_d;
      menor_q <= menor_d;
      igual_q <= igual_d;
    end
  end

  assign busy   = (state_q == S_SHIFT);
  assign done   = (state_q == S_DONE);
  assign mayor  = mayor_q;
  assign menor  = menor_q;
  assign igual  = igual_q;
  assign estado = pq_q;

endmodule

// File: tb/tb_comparador_serial_ctrl.sv
// Bench for comparador_serial_ctrl: N=8 and N=1 instances against an arithmetic
// reference model; expectations follow COMPARADOR_EARLY_EXIT_EN when defined.
module tb_comparador_serial_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       start8, busy8, done8, mayor8, menor8, igual8;
  logic [7:0] a8, b8;
  logic [1:0] est8;
  logic       start1, busy1, done1, mayor1, menor1, igual1;
  logic [0:0] a1, b1;
  logic [1:0] est1;

  comparador_serial_ctrl #(.N(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .A(a8), .B(b8),
    .busy(busy8), .done(done8), .mayor(mayor8), .menor(menor8), .igual(igual8),
    .estado(est8)
  );

  comparador_serial_ctrl #(.N(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .A(a1), .B(b1),
    .busy(busy1), .done(done1), .mayor(mayor1), .menor(menor1), .igual(igual1),
    .estado(est1)
  );

  int checks = 0;
  int failures = 0;
  bit sel = 1'b0;

  logic       s_done, s_busy;
  logic [2:0] s_verd;
  logic [1:0] s_est;
  always_comb begin
    s_done = sel ? done1 : done8;
    s_busy = sel ? busy1 : busy8;
    s_verd = sel ? {mayor1, menor1, igual1} : {mayor8, menor8, igual8};
    s_est  = sel ? est1 : est8;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] exp_verd(input logic [7:0] a, input logic [7:0] b);
    if (a > b) return 3'b100;
    if (a < b) return 3'b010;
    return 3'b001;
  endfunction

  function automatic logic [1:0] exp_est(input logic [7:0] a, input logic [7:0] b);
    if (a > b) return 2'b10;
    if (a < b) return 2'b11;
    return 2'b01;
  endfunction

  // Cycles from the accepting edge to the first cycle with done high.
  function automatic int exp_lat(input int n, input logic [7:0] a, input logic [7:0] b);
`ifdef COMPARADOR_EARLY_EXIT_EN
    for (int i = 0; i < n; i++)
      if (a[n-1-i] != b[n-1-i]) return i + 2;
`endif
    return n + 1;
  endfunction

  task automatic drive(input bit one, input logic [7:0] a, input logic [7:0] b, input logic st);
    if (one) begin
      a1 = a[0]; b1 = b[0]; start1 = st;
    end else begin
      a8 = a; b8 = b; start8 = st;
    end
  endtask

  // Called #1 after the accepting edge; returns when done is seen or the budget runs out.
  task automatic wait_done(output int lat, input bit pulse);
    lat = 1;
    while (!s_done && lat < 40) begin
      if (!sel) begin
        a8 = 8'($urandom);
        b8 = 8'($urandom);
        if (pulse) start8 = lat[0];
      end
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run(input bit one, input logic [7:0] a, input logic [7:0] b, input string tag);
    int lat, n;
    n = one ? 1 : 8;
    sel = one;
    drive(one, a, b, 1'b1);
    @(posedge clk); #1;
    if (one) start1 = 1'b0; else start8 = 1'b0;
    wait_done(lat, 1'b0);
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat(n, a, b)));
    chk({tag, "_verdict"}, 32'(s_verd), 32'(exp_verd(a, b)));
    chk({tag, "_estado"}, 32'(s_est), 32'(exp_est(a, b)));
    chk({tag, "_busy_in_done"}, 32'(s_busy), 32'(0));
    @(posedge clk); #1;
    chk({tag, "_done_pulse_ends"}, 32'(s_done), 32'(0));
    chk({tag, "_verdict_held"}, 32'(s_verd), 32'(exp_verd(a, b)));
  endtask

  initial begin
    int lat, dcount;
    logic [7:0] ra, rb;
    reset = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0;
    start1 = 1'b0; a1 = '0; b1 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs8", 32'({busy8, done8, mayor8, menor8, igual8}), 32'(0));
    chk("reset_est8", 32'(est8), 32'(2'b01));
    chk("reset_outs1", 32'({busy1, done1, mayor1, menor1, igual1}), 32'(0));
    chk("reset_est1", 32'(est1), 32'(2'b01));
    reset = 1'b0;

    // Reset in the middle of a run discards it.
    run(1'b0, 8'h3C, 8'h3C, "pre_reset_eq");
    sel = 1'b0;
    drive(1'b0, 8'hA5, 8'h5A, 1'b1);
    @(posedge clk); #1;
    start8 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("midrun_busy", 32'(busy8), 32'(1));
    reset = 1'b1;
    #1;
    chk("midrun_reset_outs", 32'({busy8, done8, mayor8, menor8, igual8}), 32'(0));
    chk("midrun_reset_est", 32'(est8), 32'(2'b01));
    #1 reset = 1'b0;
    dcount = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done8 || busy8) dcount++;
    end
    chk("no_done_after_reset", 32'(dcount), 32'(0));

    run(1'b0, 8'h3C, 8'h3C, "equal");
    run(1'b0, 8'h80, 8'h7F, "msb_differs");
    run(1'b0, 8'h10, 8'h11, "lsb_differs");

    // Back-to-back: start pulses during SHIFT ignored, start in DONE accepted.
    sel = 1'b0;
    drive(1'b0, 8'd1, 8'd2, 1'b1);
    @(posedge clk); #1;
    start8 = 1'b0;
    wait_done(lat, 1'b1);
    chk("b2b_first_latency", 32'(lat), 32'(exp_lat(8, 8'd1, 8'd2)));
    chk("b2b_first_verdict", 32'(s_verd), 32'(3'b010));
    drive(1'b0, 8'd5, 8'd5, 1'b1);
    @(posedge clk); #1;
    start8 = 1'b0;
    chk("b2b_no_bubble", 32'(busy8), 32'(1));
    chk("b2b_verdict_cleared", 32'({mayor8, menor8, igual8}), 32'(0));
    wait_done(lat, 1'b0);
    chk("b2b_second_latency", 32'(lat), 32'(exp_lat(8, 8'd5, 8'd5)));
    chk("b2b_second_verdict", 32'(s_verd), 32'(3'b001));
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++)
      run(1'b1, 8'(i >> 1), 8'(i & 1), $sformatf("n1_sweep_%0d", i));

    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ra : 8'($urandom);
      run(1'b0, ra, rb, "rand8");
    end
    for (int i = 0; i < 200; i++)
      run(1'b1, 8'($urandom_range(0, 1)), 8'($urandom_range(0, 1)), "rand1");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
